det1101_stream_arbiter: RTL and testbench
=========================================

// Module: det1101_stream_arbiter
// PURPOSE
//  Shares one 1101 Moore sequence detector (overlapping, active-low rst) between two requesters.
//  Round-robin arbiter accepts a parallel word from the granted requester and clears the detector.
//  Shifts the word MSB-first into the detector and counts its match pulses.
//  Returns a per-job match count tagged with the requester id.
// PARAMETERS
//  WIDTH  8  bits per job word, >=4
//  CNT_W  4  match-count width, saturating
// PORTS
//  clk         in   1      system clock, all logic on rising edge
//  rst         in   1      synchronous, active-high reset
//  req0_valid  in   1      requester 0 has a word
//  req0_data   in   WIDTH  requester 0 word, MSB shifted first
//  req0_ready  out  1      requester 0 word accepted this cycle
//  req1_valid  in   1      requester 1 has a word
//  req1_data   in   WIDTH  requester 1 word
//  req1_ready  out  1      requester 1 word accepted this cycle
//  det_in      out  1      serial bit to detector 'in'
//  det_rst_n   out  1      active-low reset to detector 'rst'
//  det_out     in   1      detector 'out', Moore, one cycle after the bit
//  res_valid   out  1      one-cycle result strobe
//  res_id      out  1      requester that owned the finished job
//  res_count   out  CNT_W  detector pulses counted for that job
//  busy        out  1      high in any state except IDLE
// BEHAVIOUR
//  Reset values:
//   - State IDLE, shreg=0, count=0, last_grant=1 (req0 wins first tie).
//   - res_valid=0, res_id=0, res_count=0, det_in=0, det_rst_n=0, ready=0, busy=0.
//  FSM:
//   - IDLE:
//     - Drives det_rst_n=0 and det_in=0.
//     - On a single valid, grant that requester. On both valid, grant ~last_grant.
//     - reqN_ready=1 (combinational) for the granted requester only, only in IDLE.
//     - Handshake is valid&ready. On it: load shreg<=data, id<=grant, last_grant<=grant, count<=0, bit_cnt<=0, go to SHIFT.
//   - SHIFT, WIDTH cycles:
//     - det_rst_n=1, det_in=shreg[WIDTH-1].
//     - Each cycle: shreg<<=1 and bit_cnt++. Leave after bit_cnt==WIDTH-1 and go to DRAIN.
//   - DRAIN, 1 cycle:
//     - det_rst_n=1, det_in=0. Catches the Moore output for the final bit.
//     - Go to DONE.
//   - DONE, 1 cycle:
//     - res_valid=1, res_id=id, res_count=count, det_rst_n=0. Go to IDLE.
//  Counting:
//   - count++ on every SHIFT or DRAIN cycle with det_out=1.
//   - Saturates at 2^CNT_W-1, no wrap.
//   - det_out is ignored in IDLE and DONE.
//  Detector clearing: det_rst_n is low for >=2 cycles between jobs (DONE+IDLE), so no state leaks across jobs.
//  Latency: handshake in cycle T gives res_valid in cycle T+WIDTH+2. Throughput is one job per WIDTH+3 cycles.
//  Boundaries:
//   - valid dropping while not granted: no effect.
//   - Data is sampled only at the handshake.
//   - No input is accepted while busy=1.
//   - res_id/res_count hold their value until the next DONE.
//  Reset mid-job (rst=1 in any state): next cycle is IDLE with reset values. The job is dropped and no res_valid is issued.
// TESTING (WIDTH=8, CNT_W=4 unless noted)
//  1. req0 8'b1101_1011 alone -> req0_ready at T, res_valid at T+10, res_id=0, res_count=2 (overlap).
//  2. req1 8'hFF alone -> res_id=1, res_count=0. det_rst_n low in IDLE/DONE, high for exactly 9 cycles.
//  3. req0 and req1 both valid right after reset -> req0 served first, then req1. Repeat with both valid -> alternates 0,1,0,1.
//  4. req0 held valid continuously with req1 idle -> back-to-back jobs, res_valid every 11 cycles, req0 granted each time.
//  5. CNT_W=1, req0 8'b1101_1011 -> res_count=1 (saturated, not wrapped).
//  6. rst asserted on 4th SHIFT cycle -> busy=0 next cycle, det_rst_n=0, no res_valid. A new req0 8'b0000_1101 then completes with res_count=1.

Source files
------------

// File: rtl/det1101_stream_arbiter.sv
// Round-robin front end that serialises requester words into a shared
// 1101 Moore detector and reports a saturating match count per job.
module det1101_stream_arbiter #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   input  logic [WIDTH-1:0] req0_data,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [WIDTH-1:0] req1_data,
   output logic             req1_ready,
   output logic             det_in,
   output logic             det_rst_n,
   input  logic             det_out,
   output logic             res_valid,
   output logic             res_id,
   output logic [CNT_W-1:0] res_count,
   output logic             busy
);

   localparam int BW = $clog2(WIDTH);
   localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CMAX = '1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_shreg;
   logic [BW-1:0]    r_bit_cnt;
   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] r_res_count;
   logic             r_id;
   logic             r_res_id;
   logic             r_last_grant;
   logic             w_grant;
   logic             w_hs;
   logic             w_count_en;

   // Tie goes to the requester that did not win last time.
   always_comb begin
      w_grant = req1_valid;
      if (req0_valid && req1_valid) begin
         w_grant = ~r_last_grant;
      end
   end

   assign w_hs       = (r_state == S_IDLE) && (req0_valid || req1_valid) && !rst;
   assign req0_ready = w_hs && !w_grant;
   assign req1_ready = w_hs && w_grant;

   assign w_count_en = ((r_state == S_SHIFT) || (r_state == S_DRAIN))
                       && det_out && (r_count != CMAX);

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_hs) w_next = S_SHIFT;
         S_SHIFT: if (r_bit_cnt == LAST) w_next = S_DRAIN;
         S_DRAIN: w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_shreg      <= '0;
         r_bit_cnt    <= '0;
         r_count      <= '0;
         r_res_count  <= '0;
         r_id         <= 1'b0;
         r_res_id     <= 1'b0;
         r_last_grant <= 1'b1;
      end else begin
         r_state <= w_next;
         if (w_count_en) begin
            r_count <= r_count + 1'b1;
         end
         case (r_state)
            S_IDLE: begin
               if (w_hs) begin
                  r_shreg      <= w_grant ? req1_data : req0_data;
                  r_id         <= w_grant;
                  r_last_grant <= w_grant;
                  r_count      <= '0;
                  r_bit_cnt    <= '0;
               end
            end
            S_SHIFT: begin
               r_shreg   <= {r_shreg[WIDTH-2:0], 1'b0};
               r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            S_DONE: begin
               r_res_id    <= r_id;
               r_res_count <= r_count;
            end
            default: ;
         endcase
      end
   end

   // Result fields read live in DONE and are held afterwards.
   assign res_valid = (r_state == S_DONE);
   assign res_id    = (r_state == S_DONE) ? r_id : r_res_id;
   assign res_count = (r_state == S_DONE) ? r_count : r_res_count;
   assign det_rst_n = (r_state == S_SHIFT) || (r_state == S_DRAIN);
   assign det_in    = (r_state == S_SHIFT) && r_shreg[WIDTH-1];
   assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_det1101_stream_arbiter.sv
// Randomised scoreboard bench for det1101_stream_arbiter with a behavioural
// 1101 detector on the serial side and a word-level reference model.
module tb_det1101_stream_arbiter;

   localparam int W = 8;
   localparam int C = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic         req0_valid = 1'b0;
   logic [W-1:0] req0_data  = '0;
   logic         req0_ready;
   logic         req1_valid = 1'b0;
   logic [W-1:0] req1_data  = '0;
   logic         req1_ready;
   logic         det_in, det_rst_n, det_out;
   logic         res_valid, res_id, busy;
   logic [C-1:0] res_count;

   logic         b_v0 = 1'b0;
   logic [W-1:0] b_d0 = '0;
   logic         b_r0, b_r1, b_det_in, b_det_rst_n, b_det_out;
   logic         b_res_valid, b_res_id, b_busy;
   logic [0:0]   b_res_count;

   det1101_stream_arbiter #(.WIDTH(W), .CNT_W(C)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
      .det_in(det_in), .det_rst_n(det_rst_n), .det_out(det_out),
      .res_valid(res_valid), .res_id(res_id), .res_count(res_count),
      .busy(busy)
   );

   det1101_stream_arbiter #(.WIDTH(W), .CNT_W(1)) dut_b (
      .clk(clk), .rst(rst),
      .req0_valid(b_v0), .req0_data(b_d0), .req0_ready(b_r0),
      .req1_valid(1'b0), .req1_data('0), .req1_ready(b_r1),
      .det_in(b_det_in), .det_rst_n(b_det_rst_n), .det_out(b_det_out),
      .res_valid(b_res_valid), .res_id(b_res_id), .res_count(b_res_count),
      .busy(b_busy)
   );

   // Overlapping 1101 detector: output is a function of the last four bits.
   logic [3:0] hist_a = '0;
   logic [3:0] hist_b = '0;
   always @(posedge clk) begin
      hist_a <= !det_rst_n ? 4'h0 : {hist_a[2:0], det_in};
      hist_b <= !b_det_rst_n ? 4'h0 : {hist_b[2:0], b_det_in};
   end
   assign det_out   = (hist_a == 4'b1101);
   assign b_det_out = (hist_b == 4'b1101);

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int exp_count(logic [W-1:0] w, int cw);
      int n = 0;
      for (int i = 0; i <= W - 4; i++) begin
         if (((w >> (W - 4 - i)) & 8'h0F) == 8'h0D) n++;
      end
      return (n > (1 << cw) - 1) ? (1 << cw) - 1 : n;
   endfunction

   typedef struct {
      bit id;
      int cnt;
      int cyc;
   } exp_t;

   exp_t sb[$];

   bit           m_last = 1'b1;
   int           hs     = -1000;
   logic [W-1:0] m_word = '0;

   // One bus cycle: drive after the edge, check and model at the falling edge.
   task automatic step(bit v0, logic [W-1:0] d0, bit v1, logic [W-1:0] d1, bit r);
      bit   bsy, g, e0, e1;
      logic e_in;
      @(posedge clk);
      #1;
      if (r && cyc == hs + W + 2) r = 1'b0;
      req0_valid = v0;
      req0_data  = d0;
      req1_valid = v1;
      req1_data  = d1;
      rst        = r;
      @(negedge clk);
      bsy = (cyc >= hs + 1) && (cyc <= hs + W + 2);
      g   = (v0 && v1) ? !m_last : v1;
      e0  = !r && !bsy && (v0 || v1) && !g;
      e1  = !r && !bsy && (v0 || v1) && g;
      chk("req0_ready", req0_ready, e0);
      chk("req1_ready", req1_ready, e1);
      chk("busy", busy, bsy);
      chk("det_rst_n", det_rst_n, (cyc >= hs + 1) && (cyc <= hs + W + 1));
      e_in = 1'b0;
      if (cyc >= hs + 1 && cyc <= hs + W) e_in = m_word[W - 1 - (cyc - hs - 1)];
      chk("det_in", det_in, e_in);
      if (e0 || e1) begin
         m_word = g ? d1 : d0;
         sb.push_back('{id: g, cnt: exp_count(m_word, C), cyc: cyc + W + 2});
         m_last = g;
         hs     = cyc;
      end
      if (r) begin
         sb.delete();
         m_last = 1'b1;
         hs     = -1000;
      end
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, 1'b0);
   endtask

   bit           h_id  = 1'b0;
   logic [C-1:0] h_cnt = '0;

   always @(negedge clk) begin
      exp_t e;
      if (res_valid === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_res_valid", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("res_cycle", cyc, e.cyc);
            chk("res_id", res_id, e.id);
            chk("res_count", res_count, e.cnt);
            h_id  = e.id;
            h_cnt = C'(e.cnt);
         end
      end else if (!rst) begin
         chk("hold_id", res_id, h_id);
         chk("hold_count", res_count, h_cnt);
      end
      if (rst) begin
         h_id  = 1'b0;
         h_cnt = '0;
      end
   end

   initial begin
      int  t0;
      bit  got;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_id", res_id, 0);
      chk("rst_res_count", res_count, 0);
      chk("rst_busy", busy, 0);
      chk("rst_det_rst_n", det_rst_n, 0);
      chk("rst_det_in", det_in, 0);

      // Narrow counter saturates instead of wrapping.
      @(posedge clk);
      #1;
      b_v0 = 1'b1;
      b_d0 = 8'b1101_1011;
      @(negedge clk);
      chk("b_ready0", b_r0, 1);
      t0 = cyc;
      @(posedge clk);
      #1;
      b_v0 = 1'b0;
      got  = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (b_res_valid) begin
            got = 1'b1;
            break;
         end
      end
      chk("b_res_seen", got, 1);
      if (got) begin
         chk("b_res_cycle", cyc, t0 + W + 2);
         chk("b_res_count_sat", b_res_count, 1);
         chk("b_res_id", b_res_id, 0);
      end

      step(1'b1, 8'b1101_1011, 1'b0, '0, 1'b0);
      idle(12);
      step(1'b0, '0, 1'b1, 8'hFF, 1'b0);
      idle(12);

      step(1'b0, '0, 1'b0, '0, 1'b1);
      for (int i = 0; i < 4 * (W + 3); i++) begin
         step(1'b1, W'($urandom), 1'b1, W'($urandom), 1'b0);
      end
      idle(12);

      for (int i = 0; i < 3 * (W + 3); i++) begin
         step(1'b1, W'($urandom), 1'b0, '0, 1'b0);
      end
      idle(12);

      step(1'b1, 8'hA5, 1'b0, '0, 1'b0);
      idle(3);
      step(1'b0, '0, 1'b0, '0, 1'b1);
      step(1'b1, 8'b0000_1101, 1'b0, '0, 1'b0);
      idle(12);

      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 2) != 0, W'($urandom),
              $urandom_range(0, 2) != 0, W'($urandom),
              $urandom_range(0, 99) == 0);
      end
      idle(15);
      chk("scoreboard_empty", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
